// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access owner and
// the MEM_CS/MEM_RD control encodings used by the decode stage.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic MEM_CS_ON    = 1'b1;
  localparam logic MEM_CS_OFF   = 1'b0;
  localparam logic MEM_RD_READ  = 1'b1;
  localparam logic MEM_RD_WRITE = 1'b0;

  // Decode-side helper: a selected access that is not a read is a write.
  function automatic logic dm_we_from_ctrl(input logic mem_cs_ctl, input logic mem_rd_ctl);
    return (mem_cs_ctl == MEM_CS_ON) && (mem_rd_ctl == MEM_RD_WRITE);
  endfunction

endpackage

// File: rtl/mem_arb_latency_cnt.sv
// Loadable down-counter that holds at zero; the zero flag marks the final
// cycle of a memory access.
module mem_arb_latency_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and data
// access. DM has priority; a streak limiter forces an IF grant eventually.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int DM_MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW    = $clog2(DM_MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(DM_MAX_STREAK);

  arb_state_t        state_r;
  owner_t            owner_r;
  logic [SW-1:0]     streak_r;
  logic              if_ack_r;
  logic              dm_ack_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;
  logic              mem_cs_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              grant_valid_s;
  owner_t            grant_owner_s;
  logic [SW-1:0]     streak_nxt_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;

  // Winner selection and next streak value; only consumed in IDLE.
  always_comb begin
    grant_valid_s = if_req | dm_req;
    grant_owner_s = OWN_IF;
    streak_nxt_s  = streak_r;
    if (dm_req && if_req) begin
      if (streak_r < STREAK_MAX) begin
        grant_owner_s = OWN_DM;
        streak_nxt_s  = streak_r + SW'(1);
      end else begin
        grant_owner_s = OWN_IF;
        streak_nxt_s  = {SW{1'b0}};
      end
    end else if (dm_req) begin
      grant_owner_s = OWN_DM;
    end else if (if_req) begin
      streak_nxt_s = {SW{1'b0}};
    end else begin
      grant_owner_s = OWN_IF;
    end
  end

  assign cnt_load_s = (state_r == ST_IDLE) && grant_valid_s;
  assign cnt_dec_s  = (state_r == ST_ACCESS) && !cnt_zero_s;

  mem_arb_latency_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Arbiter FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_IF;
      streak_r    <= {SW{1'b0}};
      if_ack_r    <= 1'b0;
      dm_ack_r    <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      mem_cs_r    <= MEM_CS_OFF;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      if_ack_r <= 1'b0;
      dm_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            state_r  <= ST_ACCESS;
            owner_r  <= grant_owner_s;
            streak_r <= streak_nxt_s;
            mem_cs_r <= MEM_CS_ON;
            if (grant_owner_s == OWN_DM) begin
              mem_we_r    <= dm_we;
              mem_addr_r  <= dm_addr;
              mem_wdata_r <= dm_wdata;
            end else begin
              mem_we_r    <= 1'b0;
              mem_addr_r  <= if_addr;
              mem_wdata_r <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero_s) begin
            state_r  <= ST_DONE;
            mem_cs_r <= MEM_CS_OFF;
            mem_we_r <= 1'b0;
            // Writes leave both read-data registers untouched.
            if (!mem_we_r) begin
              if (owner_r == OWN_DM) begin
                dm_rdata_r <= mem_rdata;
              end else begin
                if_rdata_r <= mem_rdata;
              end
            end else begin
              dm_rdata_r <= dm_rdata_r;
            end
            if (owner_r == OWN_DM) begin
              dm_ack_r <= 1'b1;
            end else begin
              if_ack_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_cs_r <= MEM_CS_OFF;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_r;
  assign dm_ack    = dm_ack_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_cs    = mem_cs_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign stall     = (if_req & ~if_ack_r) | (dm_req & ~dm_ack_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected acks into a queue,
// a negedge monitor pops and compares owner and read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, mem_cs, mem_we, stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic        if_ack1, dm_ack1, mem_cs1, mem_we1, stall1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

  int tests = 0;
  int failures = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem_arr [16];
  logic        prev_if_ack = 1'b0;
  logic        prev_dm_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .DM_MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .DM_MAX_STREAK(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(32'h0040_0010), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0000_0000), .dm_wdata(32'h0000_0000),
    .dm_ack(dm_ack1), .dm_rdata(dm_rdata1),
    .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(32'hCAFE_0001), .stall(stall1)
  );

  function automatic int midx(input logic [31:0] a);
    return int'({a[28], a[4:2]});
  endfunction

  // Memory model: known contents loaded on reset, writes land on the clock.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'hC0DE_0000 + 32'(i);
      mem_arr[0] <= 32'h2008_0005;
    end else if (mem_cs && mem_we) begin
      mem_arr[midx(mem_addr)] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_cs && !mem_we) ? mem_arr[midx(mem_addr)] : 32'h0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && !mem_cs) check("we_without_cs", 32'(mem_we), 32'd0);
      if (if_ack && dm_ack) check("dual_ack", 32'd1, 32'd0);
      if ((if_ack && prev_if_ack) || (dm_ack && prev_dm_ack))
        check("ack_single_cycle", 32'd2, 32'd1);
      if (if_ack || dm_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(dm_ack), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_owner", 32'(dm_ack), 32'(e.is_dm));
          check("ack_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
        end
      end
    end
    prev_if_ack <= if_ack;
    prev_dm_ack <= dm_ack;
  end

  // One isolated request from IDLE; reports cs/we cycles, latency and address slips.
  task automatic run_req(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input bit chg, input logic [31:0] chg_addr,
                         output int cs_n, output int we_n, output int lat, output int addr_bad);
    exp_t e;
    cs_n = 0; we_n = 0; lat = 0; addr_bad = 0;
    @(negedge clk);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e.is_dm = is_dm; e.rdata = exp_rd;
    exp_q.push_back(e);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_cs) begin
        cs_n++;
        if (mem_we) we_n++;
        if (mem_addr !== addr) addr_bad++;
        if (chg) dm_addr = chg_addr;
      end
      if (is_dm ? dm_ack : if_ack) begin
        lat = i;
        break;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    int cs_n, we_n, lat, abad, nack, cs1;
    int ack_t[$];
    bit owners_ok;

    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; if_req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {if_ack, dm_ack, mem_cs, mem_we, stall}, 32'd0);
    check("reset_bus", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);

    // MEM_LATENCY=1 instance, request held: ack every 3 cycles, 1 cs cycle each.
    cs1 = 0;
    if_req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_cs1) cs1++;
      if (if_ack1) ack_t.push_back(i);
    end
    if_req1 = 1'b0;
    check("l1_ack_count", 32'(ack_t.size()), 32'd4);
    check("l1_cs_cycles", 32'(cs1), 32'd4);
    if (ack_t.size() == 4) begin
      check("l1_first_ack", 32'(ack_t[0]), 32'd2);
      for (int k = 1; k < 4; k++) check("l1_ack_spacing", 32'(ack_t[k] - ack_t[k-1]), 32'd3);
    end
    check("l1_if_rdata", if_rdata1, 32'hCAFE_0001);
    check("l1_dm_rdata", dm_rdata1, 32'h0);

    // IF alone.
    run_req(1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h2008_0005, 1'b0, 32'h0, cs_n, we_n, lat, abad);
    check("if_cs_cycles", 32'(cs_n), 32'd2);
    check("if_latency", 32'(lat), 32'd3);
    @(negedge clk);
    check("if_stall_after_ack", 32'(stall), 32'd0);
    check("if_rdata_held", if_rdata, 32'h2008_0005);

    // DM write then read back.
    run_req(1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, cs_n, we_n, lat, abad);
    check("wr_we_cycles", 32'(we_n), 32'd2);
    check("wr_latency", 32'(lat), 32'd3);
    @(negedge clk);
    run_req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, cs_n, we_n, lat, abad);
    check("rd_we_cycles", 32'(we_n), 32'd0);
    check("if_rdata_after_dm", if_rdata, 32'h2008_0005);
    @(negedge clk);

    // Both held: DM x4, IF, DM.
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.is_dm = (k != 4);
      e.rdata = (k == 4) ? 32'h2008_0005 : 32'hDEAD_BEEF;
      exp_q.push_back(e);
    end
    if_addr = 32'h0040_0000; if_req = 1'b1;
    dm_addr = 32'h1001_0000; dm_we = 1'b0; dm_req = 1'b1;
    nack = 0;
    owners_ok = 1'b1;
    for (int i = 0; i < 200 && nack < 6; i++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        if (dm_ack !== (nack != 4)) owners_ok = 1'b0;
        nack++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("streak_ack_count", 32'(nack), 32'd6);
    check("streak_order", 32'(owners_ok), 32'd1);
    @(negedge clk);

    // Reset during the second ACCESS cycle of a DM read aborts it silently.
    dm_addr = 32'h1001_0000; dm_we = 1'b0; dm_req = 1'b1;
    @(negedge clk);
    check("abort_cs_first", 32'(mem_cs), 32'd1);
    @(negedge clk);
    check("abort_cs_second", 32'(mem_cs), 32'd1);
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {if_ack, dm_ack, mem_cs, mem_we, stall}, 32'd0);
    check("abort_bus", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
    check("abort_streak", 32'(dut.streak_r), 32'd0);
    repeat (4) @(negedge clk);

    // dm_addr moves mid-access; latched address must hold.
    run_req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'hC0DE_0008, 1'b1, 32'h1001_0004, cs_n, we_n, lat, abad);
    check("addr_hold", 32'(abad), 32'd0);
    check("addr_cs_cycles", 32'(cs_n), 32'd2);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences one shared single-port unified memory between two requesters: instruction fetch (IF) and data memory access (DM).
- DM requests come from the decoded MEM_CS/MEM_RD controls.
- Holds each access for a fixed memory latency, returns read data with a one-cycle ack pulse, and asserts a stall to the PC/pipeline while any request is outstanding.
- DM has priority; a streak limiter keeps IF from starving.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles mem_cs is held per access; legal range ≥1.
- DM_MAX_STREAK, 4, maximum consecutive DM grants while if_req is pending before IF is forced a grant; legal range ≥1.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- if_req in 1: fetch request, level; held until if_ack.
- if_addr in ADDR_W: fetch address; stable while if_req.
- if_ack out 1: one-cycle pulse, fetch complete.
- if_rdata out DATA_W: fetched instruction; valid from the if_ack cycle until the next IF completion.
- dm_req in 1: data request, level; held until dm_ack.
- dm_we in 1: 1 = write, 0 = read.
- dm_addr in ADDR_W: data address.
- dm_wdata in DATA_W: store data.
- dm_ack out 1: one-cycle pulse, data access complete.
- dm_rdata out DATA_W: load data; updated only by completed reads.
- mem_cs out 1: memory chip select.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data; valid in the last ACCESS cycle.
- stall out 1: combinational; (if_req & ~if_ack) | (dm_req & ~dm_ack).

Behaviour:
- Reset: state=IDLE, cnt=0, streak=0, owner=IF. All outputs and internal registers are 0.
- Reset mid-access aborts the access with no ack. mem_cs drops on the cycle after rst is sampled.
- State IDLE:
  - No request: stay IDLE.
  - Otherwise select a winner, latch addr/wdata/we/owner, set cnt=MEM_LATENCY-1, go ACCESS.
- Arbitration, evaluated in IDLE only:
  - DM alone → DM.
  - IF alone → IF.
  - Both, with streak<DM_MAX_STREAK → DM, streak+1.
  - Both, with streak==DM_MAX_STREAK → IF.
  - streak clears to 0 on any IF grant.
  - streak is unchanged on a DM grant while if_req is low.
- State ACCESS:
  - mem_cs=1; mem_addr/mem_wdata driven from latches.
  - mem_we = latched we (IF is always we=0).
  - If cnt≠0: decrement cnt.
  - If cnt==0: for a read, capture mem_rdata into the owner's rdata register; go DONE.
- State DONE:
  - mem_cs=0.
  - Owner's ack=1 for exactly this cycle; the other ack=0.
  - Go IDLE unconditionally.
- Latency: request sampled in IDLE at cycle t → ack at cycle t+MEM_LATENCY+1. Minimum request-to-request spacing is MEM_LATENCY+2 cycles.
- A requester that keeps req high after ack is treated as issuing a new request in the following IDLE.
- Requests arriving during ACCESS/DONE wait. They are never dropped and never preempt the current access.
- Address/data changes on an inputs side after grant have no effect; the latched values are used.
- dm_rdata is unchanged by DM writes; if_rdata is unchanged by DM accesses.
- mem_we is never 1 while mem_cs=0.

Decomposition:
- Shared package: the state enum (IDLE/ACCESS/DONE), an owner enum (OWN_IF/OWN_DM), and the MEM_RD/MEM_CS encodings already used by the control decode, so dm_we is derived consistently.
- Sub-module: mem_arb_latency_cnt, a loadable down-counter with a zero flag. Arbitration and FSM stay in the top.

Test Plan:
- Reset, then IF only: if_req=1, if_addr=0x00400000, mem returns 0x20080005, MEM_LATENCY=2 → mem_cs high for 2 cycles, if_ack on the 3rd cycle after grant, if_rdata=0x20080005, stall low the cycle after ack.
- DM write then read: write 0xDEADBEEF to 0x10010000 → mem_we=1 for 2 cycles, dm_ack pulse, dm_rdata stays 0. Then read the same address → dm_rdata=0xDEADBEEF.
- Simultaneous if_req and dm_req held continuously, DM_MAX_STREAK=4 → grant order DM,DM,DM,DM,IF,DM…; each ack is a single cycle.
- rst asserted during the second ACCESS cycle of a DM read → no dm_ack, mem_cs=0 next cycle, all outputs 0, streak=0.
- MEM_LATENCY=1 with back-to-back IF requests (req held) → ack every 3 cycles, mem_cs high 1 cycle each; dm_rdata unaffected.
- dm_addr changed mid-ACCESS from 0x10010000 to 0x10010004 → mem_addr stays 0x10010000 until DONE.
